// File: rtl/vram_sync_ctrl_if.sv
// Signal bundle between the CPU/PPU control side and the VRAM buffer-copy sequencer.
// The sequencer sits on the slave modport; whoever drives requests and models the sync_writers uses master.
interface vram_sync_ctrl_if #(
   parameter int NUM_RAMS = 4,
   parameter int CNT_W    = 16
);
   logic                sync_req;
   logic [NUM_RAMS-1:0] sync_mask;
   logic                vblank_start;
   logic                vblank_end;
   logic [NUM_RAMS-1:0] sw_sync;
   logic [NUM_RAMS-1:0] sw_done;
   logic                cpu_wr_lock;
   logic                pending;
   logic                busy;
   logic                sync_ack;
   logic                overrun;
   logic                overrun_clr;
   logic [CNT_W-1:0]    last_cycles;

   // Start/done are single-cycle pulses with no backpressure: sw_sync[i] is a one-cycle start,
   // sw_done[i] a one-cycle completion, and sync_req/vblank_* are one-cycle events sampled each clock.
   modport slave (
      input  sync_req, sync_mask, vblank_start, vblank_end, sw_done, overrun_clr,
      output sw_sync, cpu_wr_lock, pending, busy, sync_ack, overrun, last_cycles
   );

   modport master (
      output sync_req, sync_mask, vblank_start, vblank_end, sw_done, overrun_clr,
      input  sw_sync, cpu_wr_lock, pending, busy, sync_ack, overrun, last_cycles
   );
endinterface

// File: rtl/vram_sync_ctrl.sv
// Arms a CPU swap request and, at the next vblank start, pulses each enabled sync_writer in
// ascending order, waiting for its done; locks CPU writes while copying and times the copy.
module vram_sync_ctrl #(
   parameter int NUM_RAMS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   vram_sync_ctrl_if.slave     bus,
   output logic [1:0]          dbg_state_o
);
   localparam int IDX_W = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;
   localparam logic [NUM_RAMS-1:0] ONE_HOT0 = NUM_RAMS'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_WAIT  = 2'd3
   } state_e;

   state_e              state_q;
   logic [NUM_RAMS-1:0] mask_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [NUM_RAMS-1:0] sw_sync_q;
   logic                lock_q;
   logic                pending_q;
   logic                busy_q;
   logic                sync_ack_q;
   logic                overrun_q;
   logic [CNT_W-1:0]    last_cycles_q;

   logic                first_vld_d;
   logic [IDX_W-1:0]    first_idx_d;
   logic                next_vld_d;
   logic [IDX_W-1:0]    next_idx_d;
   logic [CNT_W-1:0]    cnt_inc_d;
   logic                copying_d;
   logic                done_hit_d;

   // Lowest enabled RAM at copy start, and the lowest enabled RAM above the current one.
   always_comb begin
      first_vld_d = 1'b0;
      first_idx_d = '0;
      next_vld_d  = 1'b0;
      next_idx_d  = '0;
      for (int i = NUM_RAMS - 1; i >= 0; i--) begin
         if (bus.sync_mask[i]) begin
            first_vld_d = 1'b1;
            first_idx_d = IDX_W'(i);
         end
         if (mask_q[i] && (i > int'(idx_q))) begin
            next_vld_d = 1'b1;
            next_idx_d = IDX_W'(i);
         end
      end
   end

   assign cnt_inc_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   assign copying_d  = (state_q == S_RUN) || (state_q == S_WAIT);
   assign done_hit_d = bus.sw_done[idx_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mask_q        <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         sw_sync_q     <= '0;
         lock_q        <= 1'b0;
         pending_q     <= 1'b0;
         busy_q        <= 1'b0;
         sync_ack_q    <= 1'b0;
         overrun_q     <= 1'b0;
         last_cycles_q <= '0;
      end else begin
         sw_sync_q  <= '0;
         sync_ack_q <= 1'b0;

         // Set has priority over clear.
         if (bus.overrun_clr) overrun_q <= 1'b0;
         if (copying_d && bus.vblank_end) overrun_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (bus.sync_req) begin
                  pending_q <= 1'b1;
                  state_q   <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (bus.vblank_start) begin
                  pending_q <= bus.sync_req;
                  mask_q    <= bus.sync_mask;
                  cnt_q     <= '0;
                  if (first_vld_d) begin
                     idx_q     <= first_idx_d;
                     sw_sync_q <= ONE_HOT0 << first_idx_d;
                     busy_q    <= 1'b1;
                     lock_q    <= 1'b1;
                     state_q   <= S_RUN;
                  end else begin
                     sync_ack_q <= 1'b1;
                     state_q    <= bus.sync_req ? S_ARMED : S_IDLE;
                  end
               end
            end
            S_RUN: begin
               cnt_q <= cnt_inc_d;
               if (bus.sync_req) pending_q <= 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_inc_d;
               if (bus.sync_req) pending_q <= 1'b1;
               if (done_hit_d) begin
                  if (next_vld_d) begin
                     idx_q     <= next_idx_d;
                     sw_sync_q <= ONE_HOT0 << next_idx_d;
                     state_q   <= S_RUN;
                  end else begin
                     // cnt_inc_d includes this done cycle in the reported duration.
                     sync_ack_q    <= 1'b1;
                     last_cycles_q <= cnt_inc_d;
                     busy_q        <= 1'b0;
                     lock_q        <= 1'b0;
                     state_q       <= (pending_q || bus.sync_req) ? S_ARMED : S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.sw_sync     = sw_sync_q;
   assign bus.cpu_wr_lock = lock_q;
   assign bus.pending     = pending_q;
   assign bus.busy        = busy_q;
   assign bus.sync_ack    = sync_ack_q;
   assign bus.overrun     = overrun_q;
   assign bus.last_cycles = last_cycles_q;
   assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_vram_sync_ctrl.sv
// Directed bench for vram_sync_ctrl: a 16-bit-counter instance and a 4-bit-counter instance
// see identical stimulus; sync_writers are modelled inline with a fixed sync-to-done span.
module tb_vram_sync_ctrl;
  logic clk;
  logic rst_n;
  logic [1:0] dbg;
  logic [1:0] dbg_sat;
  int n_checks;
  int n_errors;

  vram_sync_ctrl_if #(.NUM_RAMS(4), .CNT_W(16)) b ();
  vram_sync_ctrl_if #(.NUM_RAMS(4), .CNT_W(4))  sb ();

  assign sb.sync_req     = b.sync_req;
  assign sb.sync_mask    = b.sync_mask;
  assign sb.vblank_start = b.vblank_start;
  assign sb.vblank_end   = b.vblank_end;
  assign sb.sw_done      = b.sw_done;
  assign sb.overrun_clr  = b.overrun_clr;

  vram_sync_ctrl #(.NUM_RAMS(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave), .dbg_state_o(dbg)
  );

  vram_sync_ctrl #(.NUM_RAMS(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sb.slave), .dbg_state_o(dbg_sat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // drivers: inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_req();
    b.sync_req = 1'b1;
    tick();
    b.sync_req = 1'b0;
  endtask

  task automatic pulse_vbs();
    b.vblank_start = 1'b1;
    tick();
    b.vblank_start = 1'b0;
  endtask

  // Called in the cycle sw_sync should be high; done is returned on the lat-th cycle
  // counting the sync cycle as the first. Extras are applied in the first WAIT cycle.
  task automatic serve(input logic [3:0] exp_sync, input int lat, input logic [3:0] stray,
                       input bit vbe, input bit clr, input bit req);
    check_eq("sw_sync", 32'(b.sw_sync), 32'(exp_sync));
    check_eq("busy_run", 32'(b.busy), 32'd1);
    check_eq("lock_run", 32'(b.cpu_wr_lock), 32'd1);
    tick();
    check_eq("sw_sync_1cyc", 32'(b.sw_sync), 32'd0);
    b.sw_done     = stray;
    b.vblank_end  = vbe;
    b.overrun_clr = clr;
    b.sync_req    = req;
    tick();
    b.sw_done     = 4'b0000;
    b.vblank_end  = 1'b0;
    b.overrun_clr = 1'b0;
    b.sync_req    = 1'b0;
    if (stray != 4'b0000) begin
      check_eq("stray_no_sync", 32'(b.sw_sync), 32'd0);
      check_eq("stray_state", 32'(dbg), 32'd3);
    end
    if (vbe) check_eq("overrun_set", 32'(b.overrun), 32'd1);
    if (req) check_eq("pending_mid", 32'(b.pending), 32'd1);
    for (int i = 0; i < lat - 3; i++) tick();
    b.sw_done = exp_sync;
    tick();
    b.sw_done = 4'b0000;
  endtask

  task automatic finish_copy(input int exp_last, input bit exp_pending);
    check_eq("sync_ack", 32'(b.sync_ack), 32'd1);
    check_eq("busy_end", 32'(b.busy), 32'd0);
    check_eq("lock_end", 32'(b.cpu_wr_lock), 32'd0);
    check_eq("last_cycles", 32'(b.last_cycles), 32'(exp_last));
    check_eq("pending_end", 32'(b.pending), 32'(exp_pending));
    tick();
    check_eq("sync_ack_1cyc", 32'(b.sync_ack), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    b.sync_req = 1'b0;
    b.sync_mask = 4'b0000;
    b.vblank_start = 1'b0;
    b.vblank_end = 1'b0;
    b.sw_done = 4'b0000;
    b.overrun_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check_eq("rst_sw_sync", 32'(b.sw_sync), 32'd0);
    check_eq("rst_lock", 32'(b.cpu_wr_lock), 32'd0);
    check_eq("rst_pending", 32'(b.pending), 32'd0);
    check_eq("rst_busy", 32'(b.busy), 32'd0);
    check_eq("rst_ack", 32'(b.sync_ack), 32'd0);
    check_eq("rst_overrun", 32'(b.overrun), 32'd0);
    check_eq("rst_last", 32'(b.last_cycles), 32'd0);
    check_eq("rst_state", 32'(dbg), 32'd0);

    // basic copy, all four RAMs, 2048-cycle writers
    b.sync_mask = 4'b1111;
    pulse_req();
    check_eq("req_pending", 32'(b.pending), 32'd1);
    check_eq("req_state", 32'(dbg), 32'd1);
    tick();
    pulse_vbs();
    check_eq("vbs_pending_clr", 32'(b.pending), 32'd0);
    serve(4'b0001, 2048, 4'b0000, 1'b0, 1'b0, 1'b0);
    serve(4'b0010, 2048, 4'b0000, 1'b0, 1'b0, 1'b0);
    serve(4'b0100, 2048, 4'b0000, 1'b0, 1'b0, 1'b0);
    serve(4'b1000, 2048, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("sat_basic_last", 32'(sb.last_cycles), 32'd15);
    finish_copy(8192, 1'b0);
    check_eq("basic_idle", 32'(dbg), 32'd0);

    // sparse mask
    b.sync_mask = 4'b1010;
    pulse_req();
    pulse_vbs();
    serve(4'b0010, 5, 4'b0000, 1'b0, 1'b0, 1'b0);
    serve(4'b1000, 5, 4'b0000, 1'b0, 1'b0, 1'b0);
    finish_copy(10, 1'b0);

    // empty mask: immediate ack, no lock
    b.sync_mask = 4'b0000;
    pulse_req();
    pulse_vbs();
    check_eq("empty_ack", 32'(b.sync_ack), 32'd1);
    check_eq("empty_lock", 32'(b.cpu_wr_lock), 32'd0);
    check_eq("empty_busy", 32'(b.busy), 32'd0);
    check_eq("empty_sync", 32'(b.sw_sync), 32'd0);
    tick();
    check_eq("empty_ack_1cyc", 32'(b.sync_ack), 32'd0);
    check_eq("empty_lock2", 32'(b.cpu_wr_lock), 32'd0);
    check_eq("empty_idle", 32'(dbg), 32'd0);

    // request coinciding with vblank_start waits for the next vblank
    b.sync_mask = 4'b0001;
    b.sync_req = 1'b1;
    b.vblank_start = 1'b1;
    tick();
    b.sync_req = 1'b0;
    b.vblank_start = 1'b0;
    check_eq("same_pending", 32'(b.pending), 32'd1);
    check_eq("same_busy", 32'(b.busy), 32'd0);
    check_eq("same_sync", 32'(b.sw_sync), 32'd0);
    repeat (3) tick();
    check_eq("same_still_armed", 32'(dbg), 32'd1);
    pulse_vbs();
    serve(4'b0001, 5, 4'b0000, 1'b0, 1'b0, 1'b0);
    finish_copy(5, 1'b0);

    // mid-copy request, ignored stray done on RAM1, overrun while waiting on RAM2
    b.sync_mask = 4'b1111;
    pulse_req();
    pulse_vbs();
    serve(4'b0001, 6, 4'b0000, 1'b0, 1'b0, 1'b1);
    serve(4'b0010, 6, 4'b1000, 1'b0, 1'b0, 1'b0);
    serve(4'b0100, 6, 4'b0000, 1'b1, 1'b0, 1'b0);
    serve(4'b1000, 6, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("ovr_after_copy", 32'(b.overrun), 32'd1);
    finish_copy(24, 1'b1);
    check_eq("rearmed_state", 32'(dbg), 32'd1);
    b.sync_mask = 4'b0001;
    pulse_vbs();
    serve(4'b0001, 4, 4'b0000, 1'b0, 1'b0, 1'b0);
    finish_copy(4, 1'b0);

    // overrun clear, then clear and set together
    b.overrun_clr = 1'b1;
    tick();
    b.overrun_clr = 1'b0;
    check_eq("ovr_clr", 32'(b.overrun), 32'd0);
    pulse_req();
    pulse_vbs();
    serve(4'b0001, 6, 4'b0000, 1'b1, 1'b1, 1'b0);
    finish_copy(6, 1'b0);
    check_eq("ovr_set_wins", 32'(b.overrun), 32'd1);
    b.overrun_clr = 1'b1;
    tick();
    b.overrun_clr = 1'b0;

    // 100-cycle copy: full count vs 4-bit saturation
    pulse_req();
    pulse_vbs();
    serve(4'b0001, 100, 4'b0000, 1'b0, 1'b0, 1'b0);
    check_eq("sat_last", 32'(sb.last_cycles), 32'd15);
    finish_copy(100, 1'b0);

    // reset mid-WAIT, then a stray done from the abandoned writer
    b.sync_mask = 4'b0011;
    pulse_req();
    pulse_vbs();
    check_eq("pre_rst_sync", 32'(b.sw_sync), 32'd1);
    repeat (2) tick();
    check_eq("pre_rst_state", 32'(dbg), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mrst_sw_sync", 32'(b.sw_sync), 32'd0);
    check_eq("mrst_lock", 32'(b.cpu_wr_lock), 32'd0);
    check_eq("mrst_pending", 32'(b.pending), 32'd0);
    check_eq("mrst_busy", 32'(b.busy), 32'd0);
    check_eq("mrst_ack", 32'(b.sync_ack), 32'd0);
    check_eq("mrst_overrun", 32'(b.overrun), 32'd0);
    check_eq("mrst_last", 32'(b.last_cycles), 32'd0);
    check_eq("mrst_state", 32'(dbg), 32'd0);
    b.sw_done = 4'b0001;
    tick();
    b.sw_done = 4'b0000;
    check_eq("stray_ack", 32'(b.sync_ack), 32'd0);
    check_eq("stray_busy", 32'(b.busy), 32'd0);
    tick();
    check_eq("stray_ack2", 32'(b.sync_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vram_sync_ctrl.md
# vram_sync_ctrl

Schedules the back-to-front VRAM buffer copy for the PPU. A CPU-side swap request is armed and then serviced at the next vblank start. The controller pulses the `sync` input of up to `NUM_RAMS` `sync_writer` instances one at a time (tile, pattern, palette, sprite RAM) and waits for each `done`. It locks CPU VRAM writes while copying and reports completion, overrun and the duration of the last copy.

## Interface
Parameters:
- `NUM_RAMS`, 4: number of sync_writer instances sequenced; index 0 is serviced first.
- `CNT_W`, 16: width of the copy-duration counter.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sync_req` in 1: one-cycle swap request from the CPU register interface.
- `sync_mask` in NUM_RAMS: per-RAM enable, sampled at copy start.
- `vblank_start` in 1: one-cycle pulse from PPU timing at the first vblank line.
- `vblank_end` in 1: one-cycle pulse at the end of vblank.
- `sw_sync` out NUM_RAMS: one-hot, one-cycle start pulse to sync_writer[i].
- `sw_done` in NUM_RAMS: one-cycle completion pulse from sync_writer[i].
- `cpu_wr_lock` out 1: high while a copy is running; CPU VRAM writes stall.
- `pending` out 1: a request is armed and waiting for vblank.
- `busy` out 1: a copy is in progress.
- `sync_ack` out 1: one-cycle pulse when a swap completes.
- `overrun` out 1: sticky flag; a copy was still running at `vblank_end`.
- `overrun_clr` in 1: clears `overrun`.
- `last_cycles` out CNT_W: cycle count of the most recent copy.

## Operation
- States: IDLE, ARMED, RUN, WAIT.
- IDLE:
  - `sync_req` sets `pending` and goes to ARMED.
  - A `vblank_start` in the same cycle as `sync_req` does not start a copy; the request waits for the next vblank.
- ARMED on `vblank_start`:
  - Clear `pending`, capture `sync_mask` into `mask_q`, clear the duration counter.
  - If `mask_q` is nonzero: `idx` = lowest set bit, go to RUN.
  - If `mask_q` is zero: pulse `sync_ack`, go to IDLE. No `sw_sync` pulses, no lock.
- RUN: assert `sw_sync[idx]` for exactly one cycle, then go to WAIT.
- WAIT: only `sw_done[idx]` is honoured; a `sw_done` on any other bit is ignored. When it arrives:
  - If a higher set bit remains in `mask_q`: `idx` = that bit, go to RUN.
  - Otherwise: pulse `sync_ack`, load `last_cycles`, go to IDLE.
- `sync_req` during RUN or WAIT sets `pending`. The FSM returns to ARMED instead of IDLE after the current copy completes; `sync_ack` still pulses.
- `vblank_start` during RUN or WAIT is ignored.
- `vblank_end` during RUN or WAIT sets `overrun`. The copy continues to completion, since sync_writer cannot be aborted.
- If `overrun_clr` and a set condition occur in the same cycle, `overrun` is set (set wins).
- Duration counter:
  - Increments every cycle in RUN/WAIT.
  - Saturates at 2^CNT_W−1; no wrap.
  - `last_cycles` updates only on completion.
- Reset mid-copy returns the FSM to IDLE and clears all state. Any sync_writer already started is left running; its `done` is ignored.

## Timing
- All outputs are registered.
- Reset values: `sw_sync`=0, `cpu_wr_lock`=0, `pending`=0, `busy`=0, `sync_ack`=0, `overrun`=0, `last_cycles`=0.
- `sync_req` in cycle t: `pending`=1 in t+1.
- `vblank_start` in cycle t while ARMED:
  - `sw_sync[first]`=1, `busy`=1, `cpu_wr_lock`=1, `pending`=0 in t+1.
  - `sw_sync` returns to 0 in t+2.
- `sw_done[idx]` in cycle d with more RAMs enabled: `sw_sync[next]`=1 in d+1. There is no gap cycle; `busy` and `cpu_wr_lock` stay high.
- `sw_done[last]` in cycle d:
  - `sync_ack`=1, `busy`=0, `cpu_wr_lock`=0, `last_cycles` valid in d+1.
  - `pending` reflects any request made during the copy.
- `last_cycles` = number of cycles from the first `sw_sync` high cycle through the last `sw_done` cycle, inclusive.
- `vblank_end` in cycle e during RUN/WAIT: `overrun`=1 in e+1.
- `overrun_clr` in cycle c with no set condition: `overrun`=0 in c+1.

## Test plan
- **Reset:** hold `rst_n` low mid-WAIT, then release → all outputs 0, `pending`=0; a stray `sw_done` afterwards produces no `sync_ack`.
- **Basic copy:** mask=4'b1111, `sync_req`, then `vblank_start`; a model sync_writer returns done 2048 cycles after each sync → `sw_sync` pulses 0001, 0010, 0100, 1000, each one cycle after the previous done. `sync_ack` comes one cycle after the fourth done. `last_cycles`=8192.
- **Sparse and empty masks:**
  - mask=4'b1010 → only `sw_sync` 0010 then 1000.
  - mask=0 → `sync_ack` one cycle after `vblank_start`; `cpu_wr_lock` never rises.
- **Request timing:**
  - `sync_req` and `vblank_start` in the same cycle → no copy until the next `vblank_start`.
  - `sync_req` mid-copy → `pending`=1 after `sync_ack`; a second copy starts at the next vblank.
- **Overrun:** `vblank_end` arrives while waiting on RAM 2 → `overrun`=1 and the copy completes normally. `overrun_clr` clears it. Simultaneous clear and set leaves it 1.
- **Done filtering and saturation:**
  - `sw_done[3]` while waiting on RAM 1 → ignored.
  - With CNT_W=4, a 100-cycle copy → `last_cycles`=15.
